// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, slow-path FSM encoding, flag layout and
// single-precision field widths.
package fpu_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned SIG_W  = 23;
    localparam int unsigned MAN_W  = SIG_W + 1;   // significand incl. hidden bit
    localparam int unsigned EXT_W  = MAN_W + 4;   // {carry, sig, G, R, S}
    localparam int unsigned IEXP_W = EXP_W + 2;   // internal exponent with headroom
    localparam int unsigned FLAG_W = 5;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;
    localparam logic [31:0] POS_INF    = 32'h7F80_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } slow_state_e;

endpackage

// File: rtl/fpu_round.sv
// Combinational rounder: normalised sign/exponent/extended significand to a packed
// single-precision result with overflow and inexact indications.
module fpu_round
    import fpu_pkg::*;
(
    input  logic              sign_i,
    input  logic [IEXP_W-1:0] exp_i,
    input  logic [EXT_W-1:0]  sig_i,
    input  logic [2:0]        mode_i,
    output logic [31:0]       result_o,
    output logic              of_o,
    output logic              nx_o
);

    localparam int unsigned RND_W = MAN_W + 1;

    logic              lsb, guard, rs, inexact, inc, ovf, sat;
    logic [RND_W-1:0]  rounded;
    logic [MAN_W-1:0]  man;
    logic [IEXP_W-1:0] exp_n;

    always_comb begin
        lsb     = sig_i[3];
        guard   = sig_i[2];
        rs      = sig_i[1] | sig_i[0];
        inexact = guard | rs;

        case (mode_i)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = inexact & sign_i;
            RM_RUP:  inc = inexact & ~sign_i;
            RM_RMM:  inc = guard;
            default: inc = guard & (rs | lsb);
        endcase

        // Carry-out of the increment renormalises by one position.
        rounded = sig_i[EXT_W-1:3] + RND_W'(inc);
        if (rounded[RND_W-1]) begin
            man   = rounded[RND_W-1:1];
            exp_n = exp_i + IEXP_W'(1);
        end else begin
            man   = rounded[MAN_W-1:0];
            exp_n = exp_i;
        end

        ovf = (exp_n >= IEXP_W'(255));
        sat = (mode_i == RM_RTZ) || ((mode_i == RM_RDN) && !sign_i) ||
              ((mode_i == RM_RUP) && sign_i);

        if (ovf) begin
            result_o = sat ? {sign_i, MAX_FINITE[30:0]} : {sign_i, POS_INF[30:0]};
        end else begin
            // A subnormal that rounds into the hidden bit naturally picks up exponent 1.
            result_o = {sign_i, man[MAN_W-1] ? exp_n[EXP_W-1:0] : EXP_W'(0), man[SIG_W-1:0]};
        end

        of_o = ovf;
        nx_o = inexact | ovf;
    end

endmodule

// File: rtl/fpu_add_sub_slow.sv
// Multi-cycle single-precision add/sub: align, add, iterative normalise, round.
// Fast-stage results are passed straight through with a one-cycle latency.
module fpu_add_sub_slow
    import fpu_pkg::*;
#(
    parameter int unsigned MAX_NORM_CYC = 26
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              ready_o,
    input  logic [2:0]        rounding_mode_i,
    input  logic              sub_op_i,
    input  logic [31:0]       a_i,
    input  logic [31:0]       b_i,
    input  logic              fast_sel_i,
    input  logic [31:0]       fast_res_i,
    input  logic              invalid_fast_i,
    output logic [31:0]       result_o,
    output logic [FLAG_W-1:0] fflags_o,
    output logic              valid_o
);

    localparam int unsigned CNT_W = $clog2(MAX_NORM_CYC);

    slow_state_e       state;
    logic [31:0]       a_r, b_r;
    logic              sub_r, sign_r, eff_sub_r;
    logic [2:0]        mode_r;
    logic [IEXP_W-1:0] exp_r;
    logic [EXT_W-1:0]  big_r, small_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [EXP_W-1:0]  ea, eb, ea_eff, eb_eff, al_exp, e_sml, diff;
    logic [MAN_W-1:0]  ma, mb, m_big, m_sml;
    logic              sa, sb, a_big, al_sign, al_eff_sub;
    logic [EXT_W-1:0]  sml_ext, al_big, al_small, sum_c;
    logic [EXT_W-1:0]  norm_sig;
    logic [IEXP_W-1:0] norm_exp;
    logic              norm_done;
    logic [31:0]       rnd_res;
    logic              rnd_of, rnd_nx;
    logic [FLAG_W-1:0] rnd_flags, fast_flags;

    // Operand ordering and alignment of the smaller significand with sticky collection.
    always_comb begin
        ea     = a_r[30:23];
        eb     = b_r[30:23];
        sa     = a_r[31];
        sb     = b_r[31] ^ sub_r;
        ma     = {|ea, a_r[SIG_W-1:0]};
        mb     = {|eb, b_r[SIG_W-1:0]};
        ea_eff = (ea == '0) ? EXP_W'(1) : ea;
        eb_eff = (eb == '0) ? EXP_W'(1) : eb;
        a_big  = {ea, a_r[SIG_W-1:0]} >= {eb, b_r[SIG_W-1:0]};

        m_big      = a_big ? ma : mb;
        m_sml      = a_big ? mb : ma;
        al_exp     = a_big ? ea_eff : eb_eff;
        e_sml      = a_big ? eb_eff : ea_eff;
        al_sign    = a_big ? sa : sb;
        al_eff_sub = sa ^ sb;
        diff       = al_exp - e_sml;

        sml_ext = {1'b0, m_sml, 3'b000};
        al_big  = {1'b0, m_big, 3'b000};
        if (diff >= EXP_W'(EXT_W - 1)) begin
            al_small = EXT_W'(|m_sml);
        end else begin
            al_small = (sml_ext >> diff) |
                       EXT_W'(|(sml_ext & ~({EXT_W{1'b1}} << diff)));
        end
    end

    assign sum_c = eff_sub_r ? (big_r - small_r) : (big_r + small_r);

    // One normalisation step; exit once the hidden bit is set or the exponent bottoms out.
    always_comb begin
        norm_sig = big_r;
        norm_exp = exp_r;
        if (big_r[EXT_W-1]) begin
            norm_sig = {1'b0, big_r[EXT_W-1:2], big_r[1] | big_r[0]};
            norm_exp = exp_r + IEXP_W'(1);
        end else if (!big_r[EXT_W-2] && (exp_r > IEXP_W'(1))) begin
            norm_sig = {big_r[EXT_W-2:0], 1'b0};
            norm_exp = exp_r - IEXP_W'(1);
        end
        norm_done = norm_sig[EXT_W-2] || (norm_exp <= IEXP_W'(1));
    end

    fpu_round u_round (
        .sign_i   (sign_r),
        .exp_i    (exp_r),
        .sig_i    (big_r),
        .mode_i   (mode_r),
        .result_o (rnd_res),
        .of_o     (rnd_of),
        .nx_o     (rnd_nx)
    );

    always_comb begin
        rnd_flags           = '0;
        rnd_flags[FLAG_OF]  = rnd_of;
        rnd_flags[FLAG_NX]  = rnd_nx;
        fast_flags          = '0;
        fast_flags[FLAG_NV] = invalid_fast_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= ST_IDLE;
            ready_o   <= 1'b1;
            valid_o   <= 1'b0;
            result_o  <= '0;
            fflags_o  <= '0;
            a_r       <= '0;
            b_r       <= '0;
            sub_r     <= 1'b0;
            mode_r    <= '0;
            sign_r    <= 1'b0;
            eff_sub_r <= 1'b0;
            exp_r     <= '0;
            big_r     <= '0;
            small_r   <= '0;
            cnt_r     <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        ready_o <= 1'b0;
                        if (fast_sel_i) begin
                            result_o <= fast_res_i;
                            fflags_o <= fast_flags;
                            valid_o  <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            a_r    <= a_i;
                            b_r    <= b_i;
                            sub_r  <= sub_op_i;
                            mode_r <= rounding_mode_i;
                            state  <= ST_ALIGN;
                        end
                    end
                end
                ST_ALIGN: begin
                    sign_r    <= al_sign;
                    eff_sub_r <= al_eff_sub;
                    exp_r     <= IEXP_W'(al_exp);
                    big_r     <= al_big;
                    small_r   <= al_small;
                    state     <= ST_ADD;
                end
                ST_ADD: begin
                    if (sum_c == '0) begin
                        result_o <= {mode_r == RM_RDN, 31'b0};
                        fflags_o <= '0;
                        valid_o  <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        big_r <= sum_c;
                        cnt_r <= '0;
                        state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    big_r <= norm_sig;
                    exp_r <= norm_exp;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (norm_done || (cnt_r == CNT_W'(MAX_NORM_CYC - 1))) begin
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    result_o <= rnd_res;
                    fflags_o <= rnd_flags;
                    valid_o  <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    ready_o <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    ready_o <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
